// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and the control unit:
// fetch FSM encoding and default datapath widths.
package cpu_pkg;
  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FS_IDLE   = 2'd0;
  localparam fetch_state_t FS_FETCH  = 2'd1;
  localparam fetch_state_t FS_HALTED = 2'd2;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small FIFO with synchronous flush, combinational head read
// and occupancy count. DEPTH must be a power of two so the pointers wrap freely.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] entry [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;
      always_ff @(posedge clk) begin
        if (push && !flush && wr_ptr_reg == PTR_W'(gi)) begin
          data_reg <= push_data;
        end
      end
      assign entry[gi] = data_reg;
    end
  endgenerate

  // Flush wins over a coincident push/pop; the entry payloads need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign head_data = entry[rd_ptr_reg];
  assign count     = count_reg;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: prefetches sequential words into fetch_fifo for the control unit.
// Define FETCH_PERF_EN to add the fetch_count / flush_count performance counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
`ifdef FETCH_PERF_EN
  output logic [15:0]        fetch_count,
  output logic [7:0]         flush_count,
`endif
  output logic [1:0]         fetch_state
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = INSTR_W + PC_W;

  fetch_state_t     state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic             inflight_reg;
  logic [PC_W-1:0]  inflight_pc_reg;
  logic [CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0] fifo_head;
  logic             fifo_empty;
  logic             issue;
  logic             xfer;
  logic             fifo_push;
  logic             fifo_pop;

  assign fifo_empty = (fifo_count == '0);

  // Counting in-flight reads against capacity guarantees every return has a slot.
  assign issue = (state_reg == FS_FETCH) && !redirect_valid && !halt &&
                 ((int'(fifo_count) + int'(inflight_reg)) < DEPTH);

  assign imem_en   = issue;
  assign imem_addr = pc_reg;

  // With an empty buffer the returning word is forwarded straight to the head.
  assign instr_valid = !fifo_empty || inflight_reg;

  always_comb begin
    instr_data = '0;
    instr_pc   = '0;
    if (!fifo_empty) begin
      {instr_data, instr_pc} = fifo_head;
    end else if (inflight_reg) begin
      instr_data = imem_rdata;
      instr_pc   = inflight_pc_reg;
    end
  end

  assign xfer      = instr_valid && instr_ready;
  assign fifo_pop  = xfer && !fifo_empty;
  assign fifo_push = inflight_reg && !redirect_valid && !(xfer && fifo_empty);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_IDLE:   state_next = FS_FETCH;
      FS_FETCH:  if (!redirect_valid && halt) state_next = FS_HALTED;
      FS_HALTED: if (redirect_valid) state_next = FS_FETCH;
      default:   state_next = FS_IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (issue) begin
      pc_next = pc_reg + 1'b1;
    end
  end

  // Clearing inflight_reg on reset discards any read still returning from memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= FS_IDLE;
      pc_reg          <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;
    end
  end

  assign fetch_state = state_reg;

  fetch_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data({imem_rdata, inflight_pc_reg}),
    .pop      (fifo_pop),
    .flush    (redirect_valid),
    .head_data(fifo_head),
    .count    (fifo_count)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_reg;
  logic [7:0]  flush_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (xfer && fetch_count_reg != 16'hFFFF) fetch_count_reg <= fetch_count_reg + 16'd1;
      if (redirect_valid) flush_count_reg <= flush_count_reg + 8'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign flush_count = flush_count_reg;
`endif
endmodule
